// File: rtl/fp_div_issuer.sv
// ---------------------------------------------------------------------------
// fp_div_issuer
//
// Issue/collect front end for a fixed-latency 32-bit floating-point divider.
// Operand pairs arrive tagged over a valid/ready handshake. They are
// registered onto the divider's operand channels for one cycle each, and
// their tags are queued. Every quotient the divider returns is captured
// into a result FIFO. The divider cannot be stalled, so this capture is
// unconditional. Quotients leave in issue order together with their tags.
// Admission is credit-gated on the number of unconsumed operations, so the
// result FIFO cannot overflow while downstream stalls.
//
// Parameters
//   LATENCY    divider latency in cycles (operand tvalid -> result tvalid);
//              only feeds the no-result watchdog
//   FIFO_DEPTH result/tag FIFO depth, power of two >= 2; also the maximum
//              number of outstanding operations
//   TAG_W      side-band tag width
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   in_valid/in_ready             upstream operand handshake
//   in_a, in_b, in_tag            numerator, denominator, tag
//   div_a_tvalid/div_a_tdata      numerator channel to divider
//   div_b_tvalid/div_b_tdata      denominator channel to divider
//   div_result_tvalid/_tdata      quotient from divider (no back-pressure)
//   out_valid/out_ready           downstream handshake
//   out_q, out_tag                quotient and its tag (FIFO heads)
//   idle                          no operation outstanding
//   err                           sticky protocol error
// ---------------------------------------------------------------------------
module fp_div_issuer #(
  parameter int LATENCY    = 28,
  parameter int FIFO_DEPTH = 32,
  parameter int TAG_W      = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_a_tvalid,
  output logic [31:0]      div_a_tdata,
  output logic             div_b_tvalid,
  output logic [31:0]      div_b_tdata,
  input  logic             div_result_tvalid,
  input  logic [31:0]      div_result_tdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             idle,
  output logic             err
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  // Watchdog fires at the end of the (LATENCY+4)-th quiet cycle.
  localparam int WD_LAST = LATENCY + 3;
  localparam int WD_W    = $clog2(WD_LAST + 1);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST_C = WD_W'(WD_LAST);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_inflight;
  logic             r_div_tvalid;
  logic [31:0]      r_div_a;
  logic [31:0]      r_div_b;
  logic [AW:0]      r_res_wr;
  logic [AW:0]      r_res_rd;
  logic [AW:0]      r_tag_wr;
  logic [AW:0]      r_tag_rd;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_err;

  logic [31:0]      r_res_mem [FIFO_DEPTH];
  logic [TAG_W-1:0] r_tag_mem [FIFO_DEPTH];

  // -------------------------------------------------------------------------
  // Handshakes and FIFO status
  // -------------------------------------------------------------------------
  logic w_in_ready;
  logic w_in_hs;
  logic w_out_hs;
  logic w_res_empty;
  logic w_res_full;
  logic w_tag_empty;
  logic w_tag_full;
  logic w_res_push;
  logic w_tag_push;
  logic w_tag_pop;
  logic w_err_spur;
  logic w_err_ovf;
  logic w_err_wd;
  logic w_wd_quiet;

  // Credit check uses only registered state, so in_ready never depends on
  // in_valid.
  assign w_in_ready  = (r_outstanding < DEPTH_C);
  assign w_in_hs     = in_valid && w_in_ready;

  assign w_res_empty = (r_res_wr == r_res_rd);
  assign w_res_full  = (r_res_wr[AW] != r_res_rd[AW]) &&
                       (r_res_wr[AW-1:0] == r_res_rd[AW-1:0]);
  assign w_tag_empty = (r_tag_wr == r_tag_rd);
  assign w_tag_full  = (r_tag_wr[AW] != r_tag_rd[AW]) &&
                       (r_tag_wr[AW-1:0] == r_tag_rd[AW-1:0]);

  assign w_out_hs    = !w_res_empty && out_ready;

  // Writes into a full FIFO are dropped. In normal operation this cannot
  // happen; it is flagged through err.
  assign w_res_push  = div_result_tvalid && !w_res_full;
  assign w_tag_push  = w_in_hs && !w_tag_full;
  // The tag FIFO can only run dry relative to the result FIFO after a
  // spurious result; the guard keeps its pointers consistent then.
  assign w_tag_pop   = w_out_hs && !w_tag_empty;

  // -------------------------------------------------------------------------
  // Error detection
  // -------------------------------------------------------------------------
  assign w_err_spur  = div_result_tvalid && (r_inflight == '0);
  assign w_err_ovf   = div_result_tvalid && w_res_full;
  assign w_wd_quiet  = (r_inflight != '0) && !div_result_tvalid;
  assign w_err_wd    = w_wd_quiet && (r_wd_cnt == WD_LAST_C);

  // -------------------------------------------------------------------------
  // Outstanding-operation counter (issue to downstream pop)
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_outstanding <= '0;
    end else begin
      case ({w_in_hs, w_out_hs})
        2'b10: r_outstanding <= r_outstanding + CNT_W'(1);
        // A pop with nothing outstanding can only follow a spurious result;
        // hold at zero instead of wrapping.
        2'b01: if (r_outstanding != '0) r_outstanding <= r_outstanding - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // In-flight counter (operands sent to divider, result not yet returned)
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_inflight <= '0;
    end else begin
      case ({r_div_tvalid, div_result_tvalid})
        2'b10: r_inflight <= r_inflight + CNT_W'(1);
        2'b01: if (r_inflight != '0) r_inflight <= r_inflight - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Operand issue: one-cycle tvalid pulse per accepted pair
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_div_tvalid <= 1'b0;
      r_div_a      <= '0;
      r_div_b      <= '0;
    end else begin
      r_div_tvalid <= w_in_hs;
      if (w_in_hs) begin
        r_div_a <= in_a;
        r_div_b <= in_b;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_res_wr <= '0;
      r_res_rd <= '0;
      r_tag_wr <= '0;
      r_tag_rd <= '0;
    end else begin
      if (w_res_push) r_res_wr <= r_res_wr + (AW+1)'(1);
      if (w_out_hs)   r_res_rd <= r_res_rd + (AW+1)'(1);
      if (w_tag_push) r_tag_wr <= r_tag_wr + (AW+1)'(1);
      if (w_tag_pop)  r_tag_rd <= r_tag_rd + (AW+1)'(1);
    end
  end

  // FIFO storage has no reset; empty-gating on the outputs hides stale
  // contents.
  always_ff @(posedge aclk) begin
    if (w_res_push) r_res_mem[r_res_wr[AW-1:0]] <= div_result_tdata;
    if (w_tag_push) r_tag_mem[r_tag_wr[AW-1:0]] <= in_tag;
  end

  // -------------------------------------------------------------------------
  // Watchdog and sticky error
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wd_cnt <= '0;
    end else if (!w_wd_quiet) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != WD_LAST_C) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_err <= 1'b0;
    end else if (w_err_spur || w_err_ovf || w_err_wd) begin
      r_err <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready     = w_in_ready;
  assign div_a_tvalid = r_div_tvalid;
  assign div_b_tvalid = r_div_tvalid;
  assign div_a_tdata  = r_div_a;
  assign div_b_tdata  = r_div_b;
  assign out_valid    = !w_res_empty;
  // First-word fall-through heads, forced to zero when empty.
  assign out_q        = w_res_empty ? '0 : r_res_mem[r_res_rd[AW-1:0]];
  assign out_tag      = w_tag_empty ? '0 : r_tag_mem[r_tag_rd[AW-1:0]];
  assign idle         = (r_outstanding == '0);
  assign err          = r_err;

endmodule

// File: doc/fp_div_issuer.md
# fp_div_issuer

Issue/collect front end for the 32-bit floating-point divider core (fixed latency, no back-pressure on its result channel). Accepts tagged numerator/denominator pairs from the LCMV datapath over a valid/ready handshake, drives the divider's AXI-stream operand channels, and captures every returned quotient into an internal FIFO. Quotients leave in issue order with their tags over valid/ready. Admission is credit-gated so the result FIFO can never overflow while the downstream stalls.

## Interface
- `LATENCY`, 28, divider latency in cycles from operand tvalid to result tvalid; used only by verification and the watchdog.
- `FIFO_DEPTH`, 32, result/tag FIFO depth; power of two, ≥ 2; also the maximum number of outstanding operations.
- `TAG_W`, 8, width of the side-band tag.
- `aclk` in 1: clock, all logic on rising edge.
- `aresetn` in 1: asynchronous active-low reset.
- `in_valid` in 1: upstream operand pair valid.
- `in_ready` out 1: block can accept a pair.
- `in_a` in 32: IEEE-754 single numerator.
- `in_b` in 32: IEEE-754 single denominator.
- `in_tag` in TAG_W: tag returned with the quotient.
- `div_a_tvalid` out 1: numerator valid to divider.
- `div_a_tdata` out 32: numerator to divider.
- `div_b_tvalid` out 1: denominator valid to divider; always equal to `div_a_tvalid`.
- `div_b_tdata` out 32: denominator to divider.
- `div_result_tvalid` in 1: quotient valid from divider.
- `div_result_tdata` in 32: quotient from divider.
- `out_valid` out 1: quotient available downstream.
- `out_ready` in 1: downstream accepts.
- `out_q` out 32: quotient.
- `out_tag` out TAG_W: tag of `out_q`.
- `idle` out 1: nothing outstanding anywhere.
- `err` out 1: sticky protocol error.

## Operation
- `outstanding` counter, width clog2(FIFO_DEPTH+1):
  - +1 on input handshake (`in_valid && in_ready`).
  - −1 on output handshake (`out_valid && out_ready`).
  - Both in the same cycle: unchanged.
- `in_ready = (outstanding < FIFO_DEPTH)`, decoded from registers only; never depends on `in_valid`.
- On input handshake:
  - `in_a`/`in_b` are registered into `div_*_tdata` and `div_*_tvalid` is set the next cycle for exactly one cycle per pair.
  - `in_tag` is pushed into the tag FIFO in the same cycle.
- `inflight` counter (same width): +1 when `div_a_tvalid` is high, −1 when `div_result_tvalid` is high; both in the same cycle leaves it unchanged.
- Every cycle `div_result_tvalid` is high, `div_result_tdata` is pushed into the result FIFO. The push is unconditional, because the divider cannot be stalled.
- `out_valid` = result FIFO non-empty. `out_q`/`out_tag` are the FIFO heads (first-word fall-through).
- An output handshake pops both FIFOs.
- The divider returns results in order, so the head of the tag FIFO always pairs with the head of the result FIFO.
- `idle = (outstanding == 0)`.
- `err` is set, and held until reset, when any of these occurs:
  - `div_result_tvalid` is high while `inflight == 0`.
  - `div_result_tvalid` is high while the result FIFO is full.
  - `inflight != 0` and no result has arrived for LATENCY+4 consecutive cycles.
- On error, pushes still occur only when the target FIFO is not full; the write is dropped otherwise. No other state changes.
- The block performs no arithmetic on data. NaN, Inf and divide-by-zero results pass through unchanged.

## Timing
- Reset values:
  - `in_ready` = 1, `idle` = 1.
  - `div_a_tvalid`, `div_b_tvalid`, `out_valid`, `err` = 0.
  - `div_*_tdata`, `out_q`, `out_tag` = 0.
  - Both counters and both FIFO pointers = 0.
- Input handshake at edge t → `div_*_tvalid` high during cycle t+1.
- Result at edge t+1+LATENCY → `out_valid` high during cycle t+2+LATENCY.
- End-to-end latency with `out_ready` held high: LATENCY+2 cycles.
- Throughput: one pair per cycle sustained while `out_ready` stays high.
- Full condition: once FIFO_DEPTH pairs are unconsumed, `in_ready` = 0. The first output handshake re-raises `in_ready` on the next cycle.
- Simultaneous input and output handshakes at `outstanding == FIFO_DEPTH` are impossible, because `in_ready` is 0 then.
- Reset asserted mid-operation discards all FIFO contents and counters immediately. Results the divider returns after reset release are spurious and set `err`. Integration resets the divider with the same `aresetn`.

## Test plan
- Single op: a=0x40C00000 (6.0), b=0x40000000 (2.0), tag=0x05, handshake at edge 10, `out_ready`=1. Required:
  - `div_a_tvalid` high only in cycle 11.
  - `out_valid` first high in cycle 40 with `out_q`=0x40400000, `out_tag`=0x05.
  - `idle` returns to 1 after the pop.
- Stall fill: `out_ready`=0, `in_valid`=1, 40 pairs with tags 0..39 offered. Required:
  - Exactly 32 accepted, then `in_ready`=0.
  - After `out_ready`=1, tags 0..31 emerge in order, then tags 32..39, with none lost or duplicated and `err`=0.
- Streaming: 200 random pairs with 50%-random `out_ready`. Required:
  - Every output bit-matches the divider model in issue order.
  - `outstanding` never exceeds 32.
- Spurious result: `div_result_tvalid` pulsed with `inflight`=0. Required: `err`=1 the next cycle and held until reset.
- Reset mid-flight: 10 ops issued, `aresetn` low for 3 cycles at cycle 15 (divider also reset). Required: all outputs at reset values, then a new op completes in LATENCY+2 cycles with `err`=0.
